uart_rx: RTL

//  UART receiver: the receive counterpart of the TX path. Format is 8N1, LSB first,

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver, LSB first, line idle high.
//
// Recovers bytes from the asynchronous rx pin using an internal
// phase-accumulator tick generator running at BAUD_RATE*OVERSAMPLE.
// Each good byte is presented on rx_data with a one-cycle rx_valid
// strobe. A low stop bit gives a one-cycle frame_err strobe. The
// receiver then waits for the line to return high before it looks
// for a new start bit.
//
// Ports:
//   FPGA_CLK1_50  in   system clock, the only clock
//   reset         in   asynchronous reset, active-high
//   rx            in   serial input, asynchronous to FPGA_CLK1_50
//   rx_data       out  [7:0] last correctly framed byte, held until the next one
//   rx_valid      out  one-cycle pulse, rx_data was updated this cycle
//   frame_err     out  one-cycle pulse, stop bit sampled low
//   busy          out  high whenever the receiver is not idle
module uart_rx #(
   parameter int CLK_FREQUENCY = 50_000_000,
   parameter int BAUD_RATE     = 115_200,
   parameter int OVERSAMPLE    = 16
) (
   input  logic       FPGA_CLK1_50,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   // The accumulator carries 8 fraction bits beyond the integer clock/tick
   // ratio, which keeps the long-term tick rate error small. The increment is
   // worked out in 64 bits so the elaboration arithmetic cannot overflow.
   localparam int ACC_W = $clog2(CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE)) + 8;
   localparam logic [63:0] INC_WIDE =
      (((64'(BAUD_RATE) * 64'(OVERSAMPLE)) << ACC_W) + (64'(CLK_FREQUENCY) / 64'd2))
      / 64'(CLK_FREQUENCY);
   localparam logic [ACC_W:0] INC = INC_WIDE[ACC_W:0];

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [ACC_W:0]   acc_q, acc_d;
   state_t           state_q, state_d;
   logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             tick;
   logic             rxs;

   assign tick = acc_q[ACC_W];
   assign rxs  = sync2_q;

   // Next-state logic. The synchronizer and the tick accumulator run on
   // every clock. The receive FSM moves only on tick cycles. Start is
   // re-checked half a bit after the falling edge, which rejects short
   // glitches. After that, every sixteenth tick lands in the middle of a
   // bit. IDLE is re-entered at mid-stop-bit, so a start bit that directly
   // follows a 1-bit stop is still seen. A low stop bit parks the FSM in
   // BREAK until the line goes high again. This way a held-low line gives
   // only one frame_err.
   always_comb begin
      sync1_d     = rx;
      sync2_d     = sync1_q;
      acc_d       = {1'b0, acc_q[ACC_W-1:0]} + INC;
      state_d     = state_q;
      os_cnt_d    = os_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxs) begin
                  state_d  = S_START;
                  os_cnt_d = '0;
               end
            end
            S_START: begin
               if (os_cnt_q == OS_HALF) begin
                  if (!rxs) begin
                     state_d   = S_DATA;
                     os_cnt_d  = '0;
                     bit_cnt_d = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            S_DATA: begin
               if (os_cnt_q == OS_LAST) begin
                  shift_d   = {rxs, shift_q[7:1]};
                  os_cnt_d  = '0;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = S_STOP;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            S_STOP: begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d = '0;
                  if (rxs) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_BREAK;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            S_BREAK: begin
               if (rxs) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State register. Reset clears everything. The synchronizer resets to
   // the idle line level, so leaving reset never looks like a start bit.
   always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         acc_q       <= '0;
         state_q     <= S_IDLE;
         os_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         acc_q       <= acc_d;
         state_q     <= state_d;
         os_cnt_q    <= os_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != S_IDLE);

endmodule
